// File: rtl/compute_seq_ctrl_if.sv
// AXI4-Lite bus between compute_seq_ctrl (master) and the compute_ip register slave.
interface compute_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] m_awaddr;
  logic              m_awvalid;
  logic              m_awready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [ADDR_W-1:0] m_araddr;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready,
           m_rdata, m_rresp, m_rvalid
  );
endinterface

// File: rtl/compute_seq_ctrl.sv
// Drives one compute job through the compute_ip AXI4-Lite slave: operand/go writes,
// status polling with a bounded retry count, and a done/result report.
module compute_seq_ctrl #(
  parameter int unsigned       ADDR_W     = 4,
  parameter logic [ADDR_W-1:0] OPA_ADDR   = ADDR_W'(4'h0),
  parameter logic [ADDR_W-1:0] OPB_ADDR   = ADDR_W'(4'h4),
  parameter logic [ADDR_W-1:0] CTRL_ADDR  = ADDR_W'(4'h8),
  parameter logic [ADDR_W-1:0] STAT_ADDR  = ADDR_W'(4'hC),
  parameter int unsigned       POLL_LIMIT = 16
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               start,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  output logic               busy,
  output logic               done,
  output logic [30:0]        result,
  output logic               err,
  compute_seq_ctrl_if.master m
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = 2;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, FINISH} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  poll_cnt, poll_nxt;
  logic [DATA_W-1:0] opb;
  logic              err_flag, set_err, cap_res;
  logic [ADDR_W-1:0] beat_addr;
  logic [DATA_W-1:0] beat_data;

  // Next-state: a write beat completes only after both AW and W have handshaken.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    poll_nxt  = poll_cnt;
    set_err   = 1'b0;
    cap_res   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WRITE;
          idx_nxt   = '0;
        end
      end
      WRITE: begin
        if ((!m.m_awvalid || m.m_awready) && (!m.m_wvalid || m.m_wready))
          state_nxt = WAIT_B;
      end
      WAIT_B: begin
        if (m.m_bvalid) begin
          if (m.m_bresp != RESP_OKAY) begin
            set_err   = 1'b1;
            state_nxt = FINISH;
          end else if (idx == IDX_W'(2)) begin
            poll_nxt  = '0;
            state_nxt = READ;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = WRITE;
          end
        end
      end
      READ: begin
        if (m.m_arready) state_nxt = WAIT_R;
      end
      WAIT_R: begin
        if (m.m_rvalid) begin
          poll_nxt = poll_cnt + CNT_W'(1);
          if (m.m_rresp != RESP_OKAY) begin
            set_err   = 1'b1;
            state_nxt = FINISH;
          end else if (m.m_rdata[0]) begin
            cap_res   = 1'b1;
            state_nxt = FINISH;
          end else if (poll_nxt == CNT_W'(POLL_LIMIT)) begin
            set_err   = 1'b1;
            state_nxt = FINISH;
          end else begin
            state_nxt = READ;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat 0 takes op_a straight from the port since it launches on the accepting edge.
  always_comb begin
    beat_addr = OPA_ADDR;
    beat_data = op_a;
    case (idx_nxt)
      IDX_W'(1): begin
        beat_addr = OPB_ADDR;
        beat_data = opb;
      end
      IDX_W'(2): begin
        beat_addr = CTRL_ADDR;
        beat_data = DATA_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      idx         <= '0;
      poll_cnt    <= '0;
      opb         <= '0;
      err_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      m.m_awaddr  <= '0;
      m.m_awvalid <= 1'b0;
      m.m_wdata   <= '0;
      m.m_wstrb   <= '0;
      m.m_wvalid  <= 1'b0;
      m.m_bready  <= 1'b0;
      m.m_araddr  <= '0;
      m.m_arvalid <= 1'b0;
      m.m_rready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      poll_cnt <= poll_nxt;
      if (state == IDLE && start) opb <= op_b;
      err_flag <= (state == FINISH) ? 1'b0 : (err_flag | set_err);
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);
      err      <= (state_nxt == FINISH) && (err_flag | set_err);
      if (cap_res) result <= m.m_rdata[31:1];
      // Both valids launch together; each then drops on its own handshake.
      if (state_nxt == WRITE && state != WRITE) begin
        m.m_awaddr  <= beat_addr;
        m.m_wdata   <= beat_data;
        m.m_wstrb   <= 4'hF;
        m.m_awvalid <= 1'b1;
        m.m_wvalid  <= 1'b1;
      end else begin
        if (m.m_awready) m.m_awvalid <= 1'b0;
        if (m.m_wready)  m.m_wvalid  <= 1'b0;
      end
      m.m_bready  <= (state_nxt == WAIT_B);
      m.m_arvalid <= (state_nxt == READ);
      if (state_nxt == READ) m.m_araddr <= STAT_ADDR;
      m.m_rready  <= (state_nxt == WAIT_R);
    end
  end

endmodule

// File: tb/tb_compute_seq_ctrl.sv
// Randomized scoreboard bench for compute_seq_ctrl against a reactive AXI4-Lite slave model.
module tb_compute_seq_ctrl;

  localparam int unsigned LIMIT = 4;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rd_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; logic [30:0] result; int nrd; int nwr; int lat; int t0; } exp_t;

  logic        ACLK;
  logic        ARESETN;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [30:0] result;
  logic        err;

  compute_seq_ctrl_if #(.ADDR_W(4)) bus ();

  compute_seq_ctrl #(.POLL_LIMIT(LIMIT)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .err(err), .m(bus)
  );

  int          cmp_cnt = 0;
  int          fail_cnt = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          mode = 0;
  int          bad_beat = 3;
  int          b_beat = 0;
  logic [30:0] last_result = '0;
  rd_t         job_stat[$];
  rd_t         stat_q[$];
  wr_t         exp_wr_q[$];
  exp_t        exp_done_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    cmp_cnt++;
    if (act !== req) begin
      fail_cnt++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-channel wait states: 0..2 aw/w/ar, 3 b, 4 r.
  function automatic int pick_lat(input int ch);
    case (mode)
      1:       return (ch < 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
      2:       return (ch == 0) ? 3 : 0;
      3:       return (ch == 1) ? 3 : 0;
      default: return 0;
    endcase
  endfunction

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Slave model: decides ready/valid at each negedge, logs handshakes, checks protocol rules.
  initial begin : slave
    logic aw_got, w_got, b_pend, ar_got;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int aw_lat, w_lat, ar_lat, b_lat, r_lat;
    logic [3:0] aw_addr;
    logic [31:0] w_data;
    rd_t cur_r;
    wr_t w;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [3:0] p_awa, p_ara;
    logic [31:0] p_wd;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
    aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    aw_addr = 0; w_data = 0; cur_r.data = 0; cur_r.resp = 0;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_awa = 0; p_ara = 0; p_wd = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
        aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
        continue;
      end
      if (p_awv && !p_awr) begin
        check("awvalid_hold", 64'(bus.m_awvalid), 64'(1));
        check("awaddr_stable", 64'(bus.m_awaddr), 64'(p_awa));
      end
      if (p_awv && p_awr) check("awvalid_drop", 64'(bus.m_awvalid), 64'(0));
      if (p_wv && !p_wr) begin
        check("wvalid_hold", 64'(bus.m_wvalid), 64'(1));
        check("wdata_stable", 64'(bus.m_wdata), 64'(p_wd));
      end
      if (p_wv && p_wr) check("wvalid_drop", 64'(bus.m_wvalid), 64'(0));
      if (p_arv && !p_arr) begin
        check("arvalid_hold", 64'(bus.m_arvalid), 64'(1));
        check("araddr_stable", 64'(bus.m_araddr), 64'(p_ara));
      end
      if (bus.m_wvalid) check("wstrb", 64'(bus.m_wstrb), 64'(4'hF));
      if (bus.m_arvalid || bus.m_rready)
        check("rd_wr_overlap", 64'(bus.m_awvalid | bus.m_wvalid | bus.m_bready), 64'(0));

      bus.m_bvalid = 0; bus.m_bresp = 0;
      if (b_pend) begin
        if (b_cnt >= b_lat) begin
          bus.m_bvalid = 1;
          bus.m_bresp  = (b_beat == bad_beat) ? 2'b10 : 2'b00;
        end
        b_cnt++;
        if (bus.m_bvalid && bus.m_bready) begin
          b_pend = 0; aw_got = 0; w_got = 0; b_beat++;
        end
      end

      bus.m_awready = 0;
      if (bus.m_awvalid && !aw_got) begin
        if (aw_cnt == 0) aw_lat = pick_lat(0);
        bus.m_awready = (aw_cnt >= aw_lat);
        aw_cnt++;
        if (bus.m_awready) begin aw_got = 1; aw_addr = bus.m_awaddr; aw_cnt = 0; end
      end
      bus.m_wready = 0;
      if (bus.m_wvalid && !w_got) begin
        if (w_cnt == 0) w_lat = pick_lat(1);
        bus.m_wready = (w_cnt >= w_lat);
        w_cnt++;
        if (bus.m_wready) begin w_got = 1; w_data = bus.m_wdata; w_cnt = 0; end
      end
      if (aw_got && w_got && !b_pend) begin
        b_pend = 1; b_cnt = 0; b_lat = pick_lat(3); n_wr++;
        if (exp_wr_q.size() == 0) check("unexpected_write", 64'(aw_addr), 64'hFFFF_FFFF);
        else begin
          w = exp_wr_q.pop_front();
          check("write_addr", 64'(aw_addr), 64'(w.addr));
          check("write_data", 64'(w_data), 64'(w.data));
        end
      end

      bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
      if (ar_got) begin
        if (r_cnt >= r_lat) begin
          bus.m_rvalid = 1; bus.m_rdata = cur_r.data; bus.m_rresp = cur_r.resp;
        end
        r_cnt++;
        if (bus.m_rvalid && bus.m_rready) ar_got = 0;
      end
      bus.m_arready = 0;
      if (bus.m_arvalid && !ar_got) begin
        if (ar_cnt == 0) ar_lat = pick_lat(2);
        bus.m_arready = (ar_cnt >= ar_lat);
        ar_cnt++;
        if (bus.m_arready) begin
          ar_got = 1; ar_cnt = 0; r_cnt = 0; r_lat = pick_lat(4); n_rd++;
          check("read_addr", 64'(bus.m_araddr), 64'(4'hC));
          if (stat_q.size() != 0) cur_r = stat_q.pop_front();
          else begin cur_r.data = 0; cur_r.resp = 0; end
        end
      end

      p_awv = bus.m_awvalid; p_awr = bus.m_awready; p_awa = bus.m_awaddr;
      p_wv  = bus.m_wvalid;  p_wr  = bus.m_wready;  p_wd  = bus.m_wdata;
      p_arv = bus.m_arvalid; p_arr = bus.m_arready; p_ara = bus.m_araddr;
    end
  end

  // Completion monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ACLK);
      if (ARESETN && done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 64'(done), 64'(0));
        else begin
          e = exp_done_q.pop_front();
          check("err", 64'(err), 64'(e.err));
          check("result", 64'(result), 64'(e.result));
          check("read_count", 64'(n_rd), 64'(e.nrd));
          check("write_count", 64'(n_wr), 64'(e.nwr));
          if (e.lat >= 0) check("latency", 64'(cyc - e.t0), 64'(e.lat));
        end
        n_rd = 0;
        n_wr = 0;
        done_cnt++;
      end
    end
  end

  task automatic add_stat(input logic [31:0] d, input logic [1:0] rsp);
    rd_t r;
    r.data = d;
    r.resp = rsp;
    job_stat.push_back(r);
  endtask

  // Reference model: three register writes (stop on a write error), then status polls.
  task automatic predict(input logic [31:0] a, input logic [31:0] b, input int bad, output exp_t e);
    wr_t w;
    rd_t r;
    e.err = 0; e.result = last_result; e.nrd = 0; e.nwr = 0; e.lat = -1; e.t0 = 0;
    for (int k = 0; k < 3; k++) begin
      w.addr = 4'(4 * k);
      w.data = (k == 0) ? a : ((k == 1) ? b : 32'h1);
      exp_wr_q.push_back(w);
      e.nwr++;
      if (k == bad) begin e.err = 1; break; end
    end
    if (!e.err) begin
      for (int p = 0; p < int'(LIMIT); p++) begin
        if (p < job_stat.size()) r = job_stat[p];
        else begin r.data = 0; r.resp = 0; end
        e.nrd++;
        if (r.resp != 2'b00) begin e.err = 1; break; end
        if (r.data[0]) begin e.result = r.data[31:1]; break; end
        if (e.nrd == int'(LIMIT)) e.err = 1;
      end
    end
    if (!e.err) last_result = e.result;
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input int m,
                         input int bad, input logic stray);
    exp_t e;
    int guard;
    int d0;
    guard = 0;
    while (busy && guard < 1000) begin @(negedge ACLK); guard++; end
    check("idle_before_start", 64'(busy), 64'(0));
    mode = m; bad_beat = bad; b_beat = 0;
    stat_q = job_stat;
    predict(a, b, bad, e);
    if (m == 0) e.lat = 2 * e.nwr + 2 * e.nrd + 1;
    @(negedge ACLK);
    e.t0 = cyc;
    exp_done_q.push_back(e);
    d0 = done_cnt;
    start = 1; op_a = a; op_b = b;
    @(negedge ACLK);
    start = 0; op_a = $urandom; op_b = $urandom;
    check("busy_after_accept", 64'(busy), 64'(1));
    if (stray) begin
      repeat (3) @(negedge ACLK);
      start = 1; op_a = ~a; op_b = ~b;
      @(negedge ACLK);
      start = 0;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 2000) begin @(negedge ACLK); guard++; end
    check("done_seen", 64'(done_cnt != d0), 64'(1));
    @(negedge ACLK);
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_single_pulse", 64'(done), 64'(0));
    stat_q.delete();
    job_stat.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_result"}, 64'(result), 64'(0));
    check({tag, "_axi_valids"}, 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 64'(0));
    check({tag, "_axi_readies"}, 64'({bus.m_bready, bus.m_rready}), 64'(0));
    check({tag, "_axi_payload"}, 64'({bus.m_awaddr, bus.m_araddr, bus.m_wstrb, bus.m_wdata}), 64'(0));
  endtask

  initial begin : main
    int nk;
    int bad;
    int guard;
    int d0;
    logic [1:0] rsp;
    exp_t e;
    ARESETN = 0; start = 0; op_a = 0; op_b = 0;
    repeat (3) @(negedge ACLK);
    check_all_zero("reset");
    @(posedge ACLK); #2 ARESETN = 1;
    @(negedge ACLK);
    check_all_zero("after_reset");

    add_stat(32'h19, 2'b00);
    run_job(32'd5, 32'd7, 0, 3, 1'b0);
    add_stat(32'h19, 2'b00);
    run_job(32'hDEAD_BEEF, 32'h1234_5678, 2, 3, 1'b0);
    add_stat(32'h8001, 2'b00);
    run_job(32'hA5A5_0001, 32'h0F0F_F0F0, 3, 3, 1'b0);
    add_stat(32'h2, 2'b00); add_stat(32'h0, 2'b00); add_stat(32'h3, 2'b00);
    run_job(32'h11, 32'h22, 0, 3, 1'b0);
    for (int i = 0; i < 6; i++) add_stat(32'(2 * i + 2), 2'b00);
    run_job(32'h33, 32'h44, 0, 3, 1'b0);
    add_stat(32'h19, 2'b00);
    run_job(32'h55, 32'h66, 0, 1, 1'b0);
    add_stat(32'h21, 2'b00);
    run_job(32'h77, 32'h88, 0, 3, 1'b0);
    add_stat(32'h2, 2'b00); add_stat(32'h5, 2'b00);
    run_job(32'h99, 32'hAA, 1, 3, 1'b1);

    for (int j = 0; j < 40; j++) begin
      nk = int'($urandom_range(0, 5));
      for (int i = 0; i <= nk; i++) begin
        rsp = ($urandom_range(0, 9) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'b00;
        add_stat((i == nk) ? ($urandom | 32'h1) : ($urandom & ~32'h1), rsp);
      end
      bad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : 3;
      run_job($urandom, $urandom, int'($urandom_range(0, 3)), bad,
              (bad == 3) && ($urandom_range(0, 4) == 0));
    end

    // Abort a job in WAIT_R: outputs clear at once and no done follows.
    for (int i = 0; i < 6; i++) add_stat(32'h0, 2'b00);
    mode = 1; bad_beat = 3; b_beat = 0;
    stat_q = job_stat;
    predict(32'hCAFE_0000, 32'h0000_BEEF, 3, e);
    @(negedge ACLK);
    d0 = done_cnt;
    start = 1; op_a = 32'hCAFE_0000; op_b = 32'h0000_BEEF;
    @(negedge ACLK);
    start = 0;
    guard = 0;
    while (!bus.m_rready && guard < 500) begin @(negedge ACLK); guard++; end
    check("reached_wait_r", 64'(bus.m_rready), 64'(1));
    @(posedge ACLK);
    #2 ARESETN = 0;
    #1 check_all_zero("async_reset");
    check("writes_before_reset", 64'(exp_wr_q.size()), 64'(0));
    stat_q.delete();
    job_stat.delete();
    repeat (3) @(negedge ACLK);
    n_rd = 0; n_wr = 0; last_result = '0;
    @(posedge ACLK);
    #2 ARESETN = 1;
    repeat (20) @(negedge ACLK);
    check("no_done_after_reset", 64'(done_cnt), 64'(d0));
    check_all_zero("idle_after_abort");

    add_stat(32'h4, 2'b00); add_stat(32'hFF, 2'b00);
    run_job(32'h1, 32'h2, 0, 3, 1'b0);

    check("scoreboard_done_drained", 64'(exp_done_q.size()), 64'(0));
    check("scoreboard_writes_drained", 64'(exp_wr_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/compute_seq_ctrl.md
Name: compute_seq_ctrl

Overview:
- AXI4-Lite master sequencer that drives one compute job through the compute_ip register slave.
- Takes a start pulse with two operands, then:
  - writes operand A, operand B and the go bit;
  - polls the status register until the done bit is set or a limit is reached;
  - reads the result and returns it on a simple done/result interface.
- Sits between local control logic and the compute_ip S00_AXI port, replacing software-driven register access.

Parameters:
- ADDR_W, 4, AXI address width (byte address).
- OPA_ADDR, 4'h0, operand A register address.
- OPB_ADDR, 4'h4, operand B register address.
- CTRL_ADDR, 4'h8, control register address; a write of 32'h1 starts compute.
- STAT_ADDR, 4'hC, status/result register address; bit0 = done, bits[31:1] = result.
- POLL_LIMIT, 16, maximum status reads before timeout (1..65535).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; ignored unless idle.
- op_a  in  32  operand A, sampled when start is accepted.
- op_b  in  32  operand B, sampled when start is accepted.
- busy  out  1  high from start acceptance until the done pulse.
- done  out  1  one-cycle completion pulse.
- result  out  31  status bits[31:1] from the final read; held until the next done.
- err  out  1  qualifies done: a non-OKAY response or a timeout occurred.
- m_awaddr  out  ADDR_W  write address.
- m_awvalid  out  1  write address valid.
- m_awready  in  1  write address ready.
- m_wdata  out  32  write data.
- m_wstrb  out  4  write strobe, always 4'hF.
- m_wvalid  out  1  write data valid.
- m_wready  in  1  write data ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  write response valid.
- m_bready  out  1  write response ready.
- m_araddr  out  ADDR_W  read address.
- m_arvalid  out  1  read address valid.
- m_arready  in  1  read address ready.
- m_rdata  in  32  read data.
- m_rresp  in  2  read response.
- m_rvalid  in  1  read data valid.
- m_rready  out  1  read data ready.

Behaviour:
- Reset (ARESETN low, asynchronous): every output is 0, state is IDLE, operands are cleared, poll counter is 0.
  - Reset mid-transaction abandons the job; no done pulse is generated.
- States: IDLE, WRITE, WAIT_B, READ, WAIT_R, FINISH.
- IDLE, start=1:
  - latch op_a and op_b, set write index to 0, busy<=1, go to WRITE on the next edge.
  - start while busy is ignored and does not queue.
- WRITE:
  - Index selects the beat: 0 = OPA_ADDR/op_a, 1 = OPB_ADDR/op_b, 2 = CTRL_ADDR/32'h1.
  - awvalid and wvalid both rise on WRITE entry.
  - Each valid drops independently on its own handshake (valid&&ready on a rising edge); address and data stay stable while valid.
  - Once both handshakes are done, which may happen in the same cycle or in either order, go to WAIT_B.
- WAIT_B:
  - bready=1. On bvalid with bresp!=2'b00, set the sticky error flag and go to FINISH.
  - Otherwise index++: index<3 returns to WRITE; index==3 clears the poll counter and goes to READ.
- READ:
  - arvalid=1 with araddr=STAT_ADDR until arready, then go to WAIT_R.
- WAIT_R:
  - rready=1. On rvalid, poll counter++.
  - rresp!=OKAY: set error, go to FINISH.
  - rdata[0]=1: capture result=rdata[31:1], go to FINISH.
  - Poll counter == POLL_LIMIT: set error, go to FINISH (timeout).
  - Otherwise return to READ. There is no idle gap beyond the state transition.
- FINISH (one cycle):
  - done=1, err=sticky flag, busy<=0, clear the sticky flag, return to IDLE.
  - On error, result keeps its previous value.
- Only one AXI transaction is outstanding at any time; reads and writes never overlap.
- Latency with zero-wait slave: accept→done = 3×(WRITE+WAIT_B) + n×(READ+WAIT_R) + FINISH = 6 + 2n + 1 cycles.

Test Plan:
- Zero-wait slave, start with op_a=5, op_b=7, status read returns 32'h19 on the first poll:
  - Required: writes 0x0←5, 0x4←7, 0x8←1; one read of 0xC; done with err=0, result=31'hC.
  - Required: done is asserted 9 cycles after start acceptance.
- Slave holds awready low 3 cycles with wready=1 immediately (then the reverse case):
  - Required: wvalid drops after 1 cycle, awvalid holds until its handshake, exactly one B is awaited, sequence completes correctly.
- Status returns done=0 twice then 32'h3:
  - Required: exactly 3 reads of 0xC, result=31'h1, err=0.
- POLL_LIMIT=4 and status never done:
  - Required: exactly 4 reads, then done=1 with err=1; result unchanged from the prior job.
- bresp=SLVERR on the operand-B write:
  - Required: no CTRL write is issued; done=1 with err=1.
  - Required: the next start runs cleanly with err=0.
- ARESETN pulsed low during WAIT_R, and start asserted while busy:
  - Required: reset drives all outputs to 0 immediately with no done pulse.
  - Required: start while busy is ignored, with no second write sequence issued.
